// File: rtl/io_responder_pkg.sv
// io_responder_pkg: register indices, status bit positions and default I/O base for io_responder
package io_responder_pkg;
  typedef enum logic [2:0] {
    IO_GPIO_OUT = 3'd0,
    IO_GPIO_IN  = 3'd1,
    IO_TX_DATA  = 3'd2,
    IO_TX_STAT  = 3'd3,
    IO_TIMER    = 3'd4
  } io_reg_e;
  localparam int STAT_OVF = 15;
  localparam int STAT_FULL = 3;
  localparam int STAT_EMPTY = 2;
  localparam logic [15:0] IO_BASE_DEFAULT = 16'hFF00;
endpackage

// File: rtl/io_responder_if.sv
// io_responder_if: CPU I/O bus (iom/wen/addr/data in, data_out) plus TX ready/valid channel; master = CPU side, slave = responder
interface io_responder_if;
  logic iom_in;
  logic wen_in;
  logic [15:0] addr_in;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic [15:0] tx_data_out;
  logic tx_valid_out;
  logic tx_ready_in;
  modport master (
    output iom_in, wen_in, addr_in, data_in, tx_ready_in,
    input data_out, tx_data_out, tx_valid_out
  );
  modport slave (
    input iom_in, wen_in, addr_in, data_in, tx_ready_in,
    output data_out, tx_data_out, tx_valid_out
  );
endinterface

// File: rtl/io_responder_fifo.sv
// io_fifo: registered FIFO (clk, rst_n, push/din in, pop in, head/full/empty/count out); a push while full succeeds only alongside a pop
module io_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rp, wp;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rp <= '0;
      wp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/io_responder.sv
// io_responder: I/O-space responder (clk, rst_n, bus slave modport, gpio_in in, gpio_out out) serving GPIO, buffered TX channel and prescaled timer
module io_responder
  import io_responder_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = IO_BASE_DEFAULT,
  parameter int GPIO_W = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PRESCALE = 1000
) (
  input  logic clk,
  input  logic rst_n,
  io_responder_if.slave bus,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic sel, we, push, pop, full, empty, ovf, tick;
  logic [2:0] idx;
  logic [CW-1:0] count;
  logic [1:0] count_view;
  logic [GPIO_W-1:0] sync1, sync2;
  logic [15:0] timer, status, rdata;
  logic [PW-1:0] pre;
  assign sel = bus.iom_in & (bus.addr_in[15:3] == BASE_ADDR[15:3]);
  assign we = sel & ~bus.wen_in;
  assign idx = bus.addr_in[2:0];
  assign push = we & (idx == IO_TX_DATA);
  assign pop = bus.tx_valid_out & bus.tx_ready_in;
  assign bus.tx_valid_out = ~empty;
  assign tick = pre == PW'(PRESCALE - 1);
  assign count_view = (FIFO_DEPTH > 4 && count > CW'(3)) ? 2'd3 : count[1:0];
  assign status = {ovf, 11'b0, full, empty, count_view};
  io_fifo #(.DEPTH(FIFO_DEPTH), .W(16)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .din(bus.data_in),
    .head(bus.tx_data_out),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_comb begin
    rdata = idx == IO_GPIO_OUT ? 16'(gpio_out)
          : idx == IO_GPIO_IN  ? 16'(sync2)
          : idx == IO_TX_STAT  ? status
          : idx == IO_TIMER    ? timer
          : 16'h0000;
    bus.data_out = (sel & bus.wen_in) ? rdata : 16'h0000;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gpio_out <= '0;
      sync1 <= '0;
      sync2 <= '0;
      ovf <= 1'b0;
      timer <= '0;
      pre <= '0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
      if (we && idx == IO_GPIO_OUT) gpio_out <= bus.data_in[GPIO_W-1:0];
      if (we && idx == IO_TX_STAT) ovf <= 1'b0;
      else if (push && full && !pop) ovf <= 1'b1;
      if (we && idx == IO_TIMER) begin
        timer <= bus.data_in;
        pre <= '0;
      end else begin
        pre <= tick ? '0 : pre + PW'(1);
        if (tick) timer <= timer + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_io_responder.sv
// tb_io_responder: directed self-checking bench with TX scoreboard queue for io_responder
module tb_io_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] gpio_in = '0;
  logic [7:0] gpio_out;
  int errors = 0;
  int checks = 0;
  int mcount = 0;
  logic [15:0] q[$];
  io_responder_if bus();
  io_responder #(.PRESCALE(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .gpio_in(gpio_in),
    .gpio_out(gpio_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic iom = 1'b1);
    bus.iom_in = iom;
    bus.wen_in = 1'b0;
    bus.addr_in = a;
    bus.data_in = d;
    step();
    bus.iom_in = 1'b0;
    bus.wen_in = 1'b1;
  endtask
  task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
    bus.iom_in = 1'b1;
    bus.wen_in = 1'b1;
    bus.addr_in = a;
    #1 chk(tag, bus.data_out, exp);
    bus.iom_in = 1'b0;
  endtask
  task automatic push(input logic [15:0] d);
    wr(16'hFF02, d);
    if (mcount < 4) begin
      q.push_back(d);
      mcount++;
    end
  endtask
  task automatic drain(input string tag);
    bus.tx_ready_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_valid"}, 16'(bus.tx_valid_out), 16'(q.size() != 0));
      if (q.size() == 0) break;
      chk(tag, bus.tx_data_out, q.pop_front());
      step();
    end
    bus.tx_ready_in = 1'b0;
    mcount = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    bus.iom_in = 1'b0;
    bus.wen_in = 1'b1;
    bus.addr_in = '0;
    bus.data_in = '0;
    bus.tx_ready_in = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    rd("rst_stat", 16'hFF03, 16'h0004);
    rd("rst_timer", 16'hFF04, 16'h0000);
    chk("rst_valid", 16'(bus.tx_valid_out), 16'h0000);
    chk("rst_gpio", 16'(gpio_out), 16'h0000);
    wr(16'hFF00, 16'h00A5);
    chk("gpio_wr", 16'(gpio_out), 16'h00A5);
    rd("gpio_rd", 16'hFF00, 16'h00A5);
    wr(16'hFF00, 16'h005A, 1'b0);
    chk("gpio_nomem", 16'(gpio_out), 16'h00A5);
    wr(16'hFF08, 16'h005A);
    chk("gpio_outside", 16'(gpio_out), 16'h00A5);
    rd("miss_rd", 16'hFF08, 16'h0000);
    gpio_in = 8'h3C;
    rd("sync0", 16'hFF01, 16'h0000);
    step();
    rd("sync1", 16'hFF01, 16'h0000);
    step();
    rd("sync2", 16'hFF01, 16'h003C);
    for (int i = 0; i < 5; i++) push(16'h0011 + 16'(i));
    rd("ovf_stat", 16'hFF03, 16'h8008);
    chk("head_hold0", bus.tx_data_out, 16'h0011);
    step();
    chk("head_hold1", bus.tx_data_out, 16'h0011);
    drain("drain1");
    rd("ovf_sticky", 16'hFF03, 16'h8004);
    wr(16'hFF03, 16'hFFFF);
    rd("ovf_clear", 16'hFF03, 16'h0004);
    for (int i = 0; i < 4; i++) push(16'h0021 + 16'(i));
    rd("full_stat", 16'hFF03, 16'h0008);
    chk("fp_head", bus.tx_data_out, q.pop_front());
    bus.tx_ready_in = 1'b1;
    wr(16'hFF02, 16'h0099);
    bus.tx_ready_in = 1'b0;
    q.push_back(16'h0099);
    rd("fp_stat", 16'hFF03, 16'h0008);
    drain("drain2");
    rd("fp_empty", 16'hFF03, 16'h0004);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (3) step();
    rd("timer1", 16'hFF04, 16'h0001);
    repeat (3) step();
    rd("timer2", 16'hFF04, 16'h0002);
    wr(16'hFF04, 16'hFFFF);
    rd("timer_wr", 16'hFF04, 16'hFFFF);
    repeat (3) step();
    rd("timer_wrap", 16'hFF04, 16'h0000);
    wr(16'hFF00, 16'h0033);
    push(16'h0077);
    step();
    chk("pre_rst_valid", 16'(bus.tx_valid_out), 16'h0001);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    q.delete();
    mcount = 0;
    chk("mid_rst_gpio", 16'(gpio_out), 16'h0000);
    chk("mid_rst_valid", 16'(bus.tx_valid_out), 16'h0000);
    rd("mid_rst_stat", 16'hFF03, 16'h0004);
    rd("mid_rst_timer", 16'hFF04, 16'h0000);
    rd("mid_rst_sync", 16'hFF01, 16'h0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
